decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 in_valid / in_ready  in / out  1 / 1  fetch-side handshake; transfer when both high on a rising edge.
REQ-004 in_instr / in_pc  in  32 / 32  instruction word and its PC.
REQ-005 rf_addr1 / rf_addr2  out  5 / 5  combinational register-file read addresses = in_instr[19:15] / in_instr[24:20].
REQ-006 rf_read_data1 / rf_read_data2  in  32 / 32  combinational register-file read data.
REQ-007 wb_valid / wb_rd / wb_data  in  1 / 5 / 32  writeback port, same values driven to register-file write_en3/addr3/write_data3.
REQ-008 out_valid / out_ready  out / in  1 / 1  execute-side handshake.
REQ-009 out_pc, out_rs1_val, out_rs2_val, out_imm  out  32 each  registered decoded operands.
REQ-010 out_rd  out  5; out_opcode  out  7; out_funct3  out  3; out_funct7  out  7.
REQ-011 out_reg_write / out_illegal  out  1 / 1  instruction writes rd / opcode unrecognised.

Function
REQ-012 Latency 1 cycle: an accepted instruction appears on out_* with out_valid=1 the next cycle.
REQ-013 in_ready = (~out_valid | out_ready) & ~hazard & ~reset (combinational).
REQ-014 Output register loads on accept (in_valid & in_ready); out_valid clears on out_ready=1 with no accept; holds all out_* stable while out_valid & ~out_ready.
REQ-015 Operand usage: rs1 used by R, I-ALU, load, store, branch, JALR; rs2 used by R, store, branch; LUI/AUIPC/JAL use neither.
REQ-016 Bypass: if wb_valid & wb_rd==rsN & rsN!=0, captured rsN value = wb_data, else rf_read_dataN; rsN==0 captures 0.
REQ-017 Scoreboard: busy[31:1], one bit per register; busy[0] constant 0.
REQ-018 busy[rd] sets on accept of an instruction with reg_write=1 and rd!=0.
REQ-019 busy[wb_rd] clears on wb_valid & wb_rd!=0; set and clear of same index in same cycle -> set wins.
REQ-020 hazard = in_valid & (used rsN with busy[rsN] & ~(wb_valid & wb_rd==rsN) for N=1,2, or reg_write & busy[rd] & ~(wb_valid & wb_rd==rd)).
REQ-021 reg_write = 1 for opcodes 0110011, 0010011, 0000011, 0110111, 0010111, 1101111, 1100111, and rd!=0; else 0.
REQ-022 Immediates sign-extended to 32 bits: I (load, I-ALU, JALR), S (store 0100011), B (branch 1100011, bit0=0), U (LUI/AUIPC, low 12 bits 0), J (JAL, bit0=0); R-type imm = 0.
REQ-023 Unrecognised opcode: out_illegal=1, out_reg_write=0, out_imm=0, no scoreboard update; still passes handshake.
REQ-024 out_opcode/funct3/funct7/rd = instruction fields unchanged.

Reset
REQ-025 On reset: out_valid=0, all busy bits=0, all out_* data=0; in_ready=0 during reset cycle.
REQ-026 Reset mid-stall or with out_valid=1 discards held instruction; next cycle in_ready=1 if in_valid and no hazard.

Verification
REQ-027 Reset, then addi x1,x0,5 (0x00500093), out_ready=1 -> next cycle out_valid=1, out_rd=1, out_imm=5, out_rs1_val=0, out_reg_write=1, busy[1]=1.
REQ-028 add x3,x1,x2 (0x002081B3) with busy[1]=1, no wb -> in_ready=0 held; wb_valid=1, wb_rd=1, wb_data=190 -> accepted that cycle, out_rs1_val=190.
REQ-029 sw x2,8(x1) (0x0020A423), x1=100, x2=450 in register file -> out_imm=8, out_rs1_val=100, out_rs2_val=450, out_reg_write=0, no busy set.
REQ-030 lui x5,0x12345 (0x123452B7) with out_ready=0 for 3 cycles -> out_imm=0x12345000 stable, in_ready=0, next instruction waits until out_ready=1.
REQ-031 addi x0,x0,1 (0x00100013) -> out_reg_write=0, busy unchanged; opcode 0x7F -> out_illegal=1.
REQ-032 Assert reset with out_valid=1 and busy[3]=1 -> next cycle out_valid=0, busy all 0.

Source files
------------

// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch, register-file, writeback and execute-side signals of the decode stage.
interface decode_stage_if;
    logic        in_valid, in_ready;
    logic [31:0] in_instr, in_pc;
    logic [4:0]  rf_addr1, rf_addr2;
    logic [31:0] rf_read_data1, rf_read_data2;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        out_valid, out_ready;
    logic [31:0] out_pc, out_rs1_val, out_rs2_val, out_imm;
    logic [4:0]  out_rd;
    logic [6:0]  out_opcode, out_funct7;
    logic [2:0]  out_funct3;
    logic        out_reg_write, out_illegal;
    modport master (
        output in_valid, in_instr, in_pc, rf_read_data1, rf_read_data2, wb_valid, wb_rd, wb_data, out_ready,
        input  in_ready, rf_addr1, rf_addr2, out_valid, out_pc, out_rs1_val, out_rs2_val, out_imm,
               out_rd, out_opcode, out_funct3, out_funct7, out_reg_write, out_illegal
    );
    modport slave (
        input  in_valid, in_instr, in_pc, rf_read_data1, rf_read_data2, wb_valid, wb_rd, wb_data, out_ready,
        output in_ready, rf_addr1, rf_addr2, out_valid, out_pc, out_rs1_val, out_rs2_val, out_imm,
               out_rd, out_opcode, out_funct3, out_funct7, out_reg_write, out_illegal
    );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode with register-file bypass, busy scoreboard and a one-entry output register.
module decode_stage (
    input logic     clk,
    input logic     reset,
    decode_stage_if.slave d
);
    logic [31:0] instr, imm, busy, rs1_val, rs2_val, set_mask, clr_mask;
    logic [6:0]  op;
    logic [4:0]  rs1, rs2, rd;
    logic is_r, is_i, is_ld, is_st, is_br, is_lui, is_aui, is_jal, is_jalr, legal;
    logic use1, use2, reg_write, hit1, hit2, hit_rd, hazard, accept;
    assign instr   = d.in_instr;
    assign op      = instr[6:0];
    assign rd      = instr[11:7];
    assign rs1     = instr[19:15];
    assign rs2     = instr[24:20];
    assign is_r    = op == 7'b0110011;
    assign is_i    = op == 7'b0010011;
    assign is_ld   = op == 7'b0000011;
    assign is_st   = op == 7'b0100011;
    assign is_br   = op == 7'b1100011;
    assign is_lui  = op == 7'b0110111;
    assign is_aui  = op == 7'b0010111;
    assign is_jal  = op == 7'b1101111;
    assign is_jalr = op == 7'b1100111;
    assign legal   = is_r | is_i | is_ld | is_st | is_br | is_lui | is_aui | is_jal | is_jalr;
    assign use1    = is_r | is_i | is_ld | is_st | is_br | is_jalr;
    assign use2    = is_r | is_st | is_br;
    assign reg_write = (is_r | is_i | is_ld | is_lui | is_aui | is_jal | is_jalr) & (rd != 5'd0);
    assign imm = (is_i | is_ld | is_jalr) ? {{20{instr[31]}}, instr[31:20]} :
                 is_st ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
                 is_br ? {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} :
                 (is_lui | is_aui) ? {instr[31:12], 12'd0} :
                 is_jal ? {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0} : 32'd0;
    assign d.rf_addr1 = rs1;
    assign d.rf_addr2 = rs2;
    assign hit1    = d.wb_valid & (d.wb_rd == rs1);
    assign hit2    = d.wb_valid & (d.wb_rd == rs2);
    assign hit_rd  = d.wb_valid & (d.wb_rd == rd);
    assign rs1_val = (rs1 == 5'd0) ? 32'd0 : hit1 ? d.wb_data : d.rf_read_data1;
    assign rs2_val = (rs2 == 5'd0) ? 32'd0 : hit2 ? d.wb_data : d.rf_read_data2;
    // a writeback landing this cycle resolves the dependency, so it does not stall
    assign hazard  = d.in_valid & ((use1 & busy[rs1] & ~hit1) | (use2 & busy[rs2] & ~hit2) |
                                   (reg_write & busy[rd] & ~hit_rd));
    assign d.in_ready = (~d.out_valid | d.out_ready) & ~hazard & ~reset;
    assign accept   = d.in_valid & d.in_ready;
    assign set_mask = (accept & reg_write) ? (32'd1 << rd) : 32'd0;
    assign clr_mask = d.wb_valid ? (32'd1 << d.wb_rd) : 32'd0;
    always_ff @(posedge clk) begin
        if (reset) busy <= 32'd0;
        else busy <= ((busy & ~clr_mask) | set_mask) & ~32'd1;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            d.out_valid     <= 1'b0;
            d.out_pc        <= 32'd0;
            d.out_rs1_val   <= 32'd0;
            d.out_rs2_val   <= 32'd0;
            d.out_imm       <= 32'd0;
            d.out_rd        <= 5'd0;
            d.out_opcode    <= 7'd0;
            d.out_funct3    <= 3'd0;
            d.out_funct7    <= 7'd0;
            d.out_reg_write <= 1'b0;
            d.out_illegal   <= 1'b0;
        end else if (accept) begin
            d.out_valid     <= 1'b1;
            d.out_pc        <= d.in_pc;
            d.out_rs1_val   <= rs1_val;
            d.out_rs2_val   <= rs2_val;
            d.out_imm       <= imm;
            d.out_rd        <= rd;
            d.out_opcode    <= op;
            d.out_funct3    <= instr[14:12];
            d.out_funct7    <= instr[31:25];
            d.out_reg_write <= reg_write;
            d.out_illegal   <= ~legal;
        end else if (d.out_ready) begin
            d.out_valid     <= 1'b0;
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: randomized scoreboard bench with a behavioural decode/hazard model for decode_stage.
module tb_decode_stage;
    typedef struct packed {
        logic [31:0] pc, rs1, rs2, imm;
        logic [4:0]  rd;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        rw, ill;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    decode_stage_if d();
    decode_stage dut (.clk(clk), .reset(reset), .d(d));

    logic [31:0] rf [32];
    assign d.rf_read_data1 = rf[d.rf_addr1];
    assign d.rf_read_data2 = rf[d.rf_addr2];

    exp_t q[$];
    bit   pend [32];
    bit   mv;
    int   checks = 0;
    int   errors = 0;
    logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h7F};

    task automatic check1(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    // fmt: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 unknown
    function automatic void classify(input logic [6:0] op, output bit u1, output bit u2,
                                     output bit wr, output bit lg, output int fmt);
        u1 = 0; u2 = 0; wr = 0; lg = 1; fmt = 6;
        case (op)
            7'h33: begin u1 = 1; u2 = 1; wr = 1; fmt = 0; end
            7'h13, 7'h03, 7'h67: begin u1 = 1; wr = 1; fmt = 1; end
            7'h23: begin u1 = 1; u2 = 1; fmt = 2; end
            7'h63: begin u1 = 1; u2 = 1; fmt = 3; end
            7'h37, 7'h17: begin wr = 1; fmt = 4; end
            7'h6F: begin wr = 1; fmt = 5; end
            default: lg = 0;
        endcase
    endfunction

    function automatic logic [31:0] imm_of(input logic [31:0] i, input int fmt);
        int v;
        case (fmt)
            1: v = int'($signed(i[31:20]));
            2: v = int'($signed({i[31:25], i[11:7]}));
            3: v = int'($signed({i[31], i[7], i[30:25], i[11:8]})) * 2;
            4: v = int'(i[31:12]) << 12;
            5: v = int'($signed({i[31], i[19:12], i[20], i[30:21]})) * 2;
            default: v = 0;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] opnd(input logic [4:0] r, input bit wv, input logic [4:0] wrd,
                                         input logic [31:0] wdat);
        if (r == 0) return 0;
        return (wv && wrd == r) ? wdat : rf[r];
    endfunction

    function automatic bit waiting(input logic [4:0] r, input bit wv, input logic [4:0] wrd);
        return r != 0 && pend[r] && !(wv && wrd == r);
    endfunction

    function automatic bit hazard_m(input bit iv, input logic [31:0] i, input bit wv, input logic [4:0] wrd);
        bit u1, u2, wr, lg;
        int fmt;
        classify(i[6:0], u1, u2, wr, lg, fmt);
        return iv && ((u1 && waiting(i[19:15], wv, wrd)) || (u2 && waiting(i[24:20], wv, wrd)) ||
                      (wr && i[11:7] != 0 && waiting(i[11:7], wv, wrd)));
    endfunction

    function automatic exp_t expect_of(input logic [31:0] i, input logic [31:0] pc, input bit wv,
                                       input logic [4:0] wrd, input logic [31:0] wdat);
        exp_t e;
        bit u1, u2, wr, lg;
        int fmt;
        classify(i[6:0], u1, u2, wr, lg, fmt);
        e.pc = pc; e.rs1 = opnd(i[19:15], wv, wrd, wdat); e.rs2 = opnd(i[24:20], wv, wrd, wdat);
        e.imm = imm_of(i, fmt); e.rd = i[11:7]; e.op = i[6:0]; e.f3 = i[14:12]; e.f7 = i[31:25];
        e.rw = wr && i[11:7] != 0; e.ill = !lg;
        return e;
    endfunction

    task automatic cycle(input bit iv, input logic [31:0] ins, input logic [31:0] pc, input bit ordy,
                         input bit wv, input logic [4:0] wrd, input logic [31:0] wdat);
        bit er, acc;
        exp_t e;
        @(negedge clk);
        d.in_valid = iv; d.in_instr = ins; d.in_pc = pc; d.out_ready = ordy;
        d.wb_valid = wv; d.wb_rd = wrd; d.wb_data = wdat;
        #1;
        er = (!mv || ordy) && !hazard_m(iv, ins, wv, wrd);
        check1("in_ready", 32'(d.in_ready), 32'(er));
        check1("out_valid", 32'(d.out_valid), 32'(mv));
        acc = iv && er;
        e = expect_of(ins, pc, wv, wrd, wdat);
        if (acc) q.push_back(e);
        @(posedge clk);
        #1;
        if (wv && wrd != 0) begin pend[wrd] = 0; rf[wrd] = wdat; end
        if (acc && e.rw) pend[e.rd] = 1;
        mv = acc ? 1'b1 : (ordy ? 1'b0 : mv);
    endtask

    task automatic do_reset(input bit iv);
        @(negedge clk);
        reset = 1; d.in_valid = iv; d.in_instr = 32'h00500093; d.out_ready = 0; d.wb_valid = 0;
        #1;
        check1("in_ready_in_reset", 32'(d.in_ready), 0);
        @(posedge clk);
        #1;
        reset = 0;
        q.delete();
        pend = '{default: 0};
        mv = 0;
        check1("rst_out_valid", 32'(d.out_valid), 0);
        check1("rst_out_imm", d.out_imm, 0);
        check1("rst_out_pc", d.out_pc, 0);
        check1("rst_out_rd", 32'(d.out_rd), 0);
    endtask

    // monitor: held output must match the queue head every cycle; pops on transfer
    always @(negedge clk) begin
        exp_t got;
        #2;
        if (d.out_valid === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected: out_valid=1 with nothing expected at %0t", $time);
            end else begin
                got = '{d.out_pc, d.out_rs1_val, d.out_rs2_val, d.out_imm, d.out_rd, d.out_opcode,
                        d.out_funct3, d.out_funct7, d.out_reg_write, d.out_illegal};
                if (got !== q[0]) begin
                    errors++;
                    $display("FAIL out_fields: got %h expected %h at %0t", got, q[0], $time);
                end
                if (d.out_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        d.in_valid = 0; d.in_instr = 0; d.in_pc = 0; d.out_ready = 0;
        d.wb_valid = 0; d.wb_rd = 0; d.wb_data = 0;
        for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'd0 : $urandom;
        pend = '{default: 0};
        mv = 0;
        do_reset(1);
        cycle(1, 32'h00500093, 32'h100, 1, 0, 0, 0);
        cycle(1, 32'h002081B3, 32'h104, 1, 0, 0, 0);
        cycle(1, 32'h002081B3, 32'h104, 1, 0, 0, 0);
        cycle(1, 32'h002081B3, 32'h104, 1, 1, 5'd1, 32'd190);
        rf[1] = 32'd100; rf[2] = 32'd450;
        cycle(1, 32'h0020A423, 32'h108, 1, 0, 0, 0);
        cycle(1, 32'h123452B7, 32'h10C, 1, 0, 0, 0);
        repeat (3) cycle(1, 32'h00100313, 32'h110, 0, 0, 0, 0);
        cycle(1, 32'h00100313, 32'h110, 1, 0, 0, 0);
        cycle(1, 32'h00100013, 32'h114, 1, 0, 0, 0);
        cycle(1, 32'h0000007F, 32'h118, 1, 0, 0, 0);
        cycle(1, 32'h00100393, 32'h11C, 0, 0, 0, 0);
        do_reset(1);
        cycle(1, 32'h00318233, 32'h120, 1, 0, 0, 0);
        repeat (3000) begin
            logic [31:0] ins;
            if ($urandom_range(0, 199) == 0) do_reset($urandom_range(0, 1) == 1);
            ins = $urandom;
            ins[6:0] = ops[$urandom_range(0, 9)];
            ins[11:7] = 5'($urandom_range(0, 7));
            ins[19:15] = 5'($urandom_range(0, 7));
            ins[24:20] = 5'($urandom_range(0, 7));
            cycle($urandom_range(0, 3) != 0, ins, $urandom, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
        end
        repeat (3) cycle(0, 0, 0, 1, 0, 0, 0);
        check1("drain_empty", 32'(q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
